// File: rtl/mips_bus_arbiter.sv
// Two-master (ifetch/data) to single memory-bus arbiter: one transfer at a time, IDLE -> ISSUE [-> RDATA] -> IDLE.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m1 (data) wins ties.
module mips_bus_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_m0_address,
    input  logic        i_m0_read,
    input  logic        i_m0_write,
    input  logic [31:0] i_m0_writedata,
    input  logic [3:0]  i_m0_byteenable,
    output logic        o_m0_waitrequest,
    output logic [31:0] o_m0_readdata,
    input  logic [31:0] i_m1_address,
    input  logic        i_m1_read,
    input  logic        i_m1_write,
    input  logic [31:0] i_m1_writedata,
    input  logic [3:0]  i_m1_byteenable,
    output logic        o_m1_waitrequest,
    output logic [31:0] o_m1_readdata,
    output logic [31:0] o_s_address,
    output logic        o_s_read,
    output logic        o_s_write,
    output logic [31:0] o_s_writedata,
    output logic [3:0]  o_s_byteenable,
    input  logic        i_s_waitrequest,
    input  logic [31:0] i_s_readdata,
    output logic [1:0]  o_grant
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

    state_t r_state;
    logic   r_owner;

    logic        w_req0, w_req1, w_pick;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_be;
    logic        w_wr, w_rd, w_done;

    assign w_req0 = i_m0_read | i_m0_write;
    assign w_req1 = i_m1_read | i_m1_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;
    assign w_pick = (w_req0 && w_req1) ? ~r_last : w_req1;
`else
    assign w_pick = w_req1;
`endif

    // Read+write together is a write; the read strobe is ignored.
    assign w_addr  = r_owner ? i_m1_address    : i_m0_address;
    assign w_wdata = r_owner ? i_m1_writedata  : i_m0_writedata;
    assign w_be    = r_owner ? i_m1_byteenable : i_m0_byteenable;
    assign w_wr    = r_owner ? i_m1_write      : i_m0_write;
    assign w_rd    = (r_owner ? i_m1_read : i_m0_read) & ~w_wr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last  <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_req0 || w_req1) begin
                    r_owner <= w_pick;
`ifdef ARB_ROUND_ROBIN_EN
                    r_last  <= w_pick;
`endif
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    // Owner withdrawing its strobe mid-transfer aborts without a completion.
                    if (!w_wr && !w_rd)
                        r_state <= IDLE;
                    else if (!i_s_waitrequest)
                        r_state <= w_wr ? IDLE : RDATA;
                end
                RDATA:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_s_address    = '0;
        o_s_read       = 1'b0;
        o_s_write      = 1'b0;
        o_s_writedata  = '0;
        o_s_byteenable = '0;
        o_grant        = 2'b00;
        w_done         = 1'b0;
        case (r_state)
            ISSUE: begin
                o_s_address    = w_addr;
                o_s_read       = w_rd;
                o_s_write      = w_wr;
                o_s_writedata  = w_wdata;
                o_s_byteenable = w_be;
                o_grant        = r_owner ? 2'b10 : 2'b01;
                w_done         = w_wr & ~i_s_waitrequest & ~i_reset;
            end
            RDATA: begin
                o_grant = r_owner ? 2'b10 : 2'b01;
                w_done  = ~i_reset;
            end
            default: ;
        endcase
    end

    assign o_m0_waitrequest = ~(w_done & ~r_owner);
    assign o_m1_waitrequest = ~(w_done &  r_owner);
    assign o_m0_readdata    = (r_state == RDATA && !r_owner) ? i_s_readdata : 32'd0;
    assign o_m1_readdata    = (r_state == RDATA &&  r_owner) ? i_s_readdata : 32'd0;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: completions are matched against a queue of expected transfers.
module tb_mips_bus_arbiter;
    logic        i_clk, i_reset;
    logic [31:0] i_m0_address, i_m0_writedata, i_m1_address, i_m1_writedata;
    logic        i_m0_read, i_m0_write, i_m1_read, i_m1_write;
    logic [3:0]  i_m0_byteenable, i_m1_byteenable;
    logic        o_m0_waitrequest, o_m1_waitrequest;
    logic [31:0] o_m0_readdata, o_m1_readdata;
    logic [31:0] o_s_address, o_s_writedata;
    logic        o_s_read, o_s_write;
    logic [3:0]  o_s_byteenable;
    logic        i_s_waitrequest;
    logic [31:0] i_s_readdata;
    logic [1:0]  o_grant;

    typedef struct {
        bit          m;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;

    mips_bus_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_address(i_m0_address), .i_m0_read(i_m0_read), .i_m0_write(i_m0_write),
        .i_m0_writedata(i_m0_writedata), .i_m0_byteenable(i_m0_byteenable),
        .o_m0_waitrequest(o_m0_waitrequest), .o_m0_readdata(o_m0_readdata),
        .i_m1_address(i_m1_address), .i_m1_read(i_m1_read), .i_m1_write(i_m1_write),
        .i_m1_writedata(i_m1_writedata), .i_m1_byteenable(i_m1_byteenable),
        .o_m1_waitrequest(o_m1_waitrequest), .o_m1_readdata(o_m1_readdata),
        .o_s_address(o_s_address), .o_s_read(o_s_read), .o_s_write(o_s_write),
        .o_s_writedata(o_s_writedata), .o_s_byteenable(o_s_byteenable),
        .i_s_waitrequest(i_s_waitrequest), .i_s_readdata(i_s_readdata),
        .o_grant(o_grant)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, {30'd0, o_grant}, 32'd0);
        chk({tag, "_sread"}, {31'd0, o_s_read}, 32'd0);
        chk({tag, "_swrite"}, {31'd0, o_s_write}, 32'd0);
        chk({tag, "_saddr"}, o_s_address, 32'd0);
    endtask

    task automatic push(input bit m, input bit rd, input logic [31:0] data);
        exp_t e;
        e.m = m; e.rd = rd; e.data = data;
        sb.push_back(e);
    endtask

    // Completion monitor: every waitrequest-low pulse must match the oldest expected transfer.
    always @(negedge i_clk) begin
        if (o_m0_waitrequest) chk("m0_rdata_zero", o_m0_readdata, 32'd0);
        if (o_m1_waitrequest) chk("m1_rdata_zero", o_m1_readdata, 32'd0);
        if (o_m0_waitrequest === 1'b0 || o_m1_waitrequest === 1'b0) begin
            if (sb.size() == 0) begin
                ncmp++;
                nerr++;
                $error("FAIL spurious_done: observed wr0=%b wr1=%b expected no completion",
                       o_m0_waitrequest, o_m1_waitrequest);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_master", {30'd0, ~o_m1_waitrequest, ~o_m0_waitrequest}, e.m ? 32'd2 : 32'd1);
                if (e.rd) chk("done_rdata", e.m ? o_m1_readdata : o_m0_readdata, e.data);
            end
        end
    end

    logic [31:0] d4 [3];
    logic [1:0]  g4 [3];

    initial begin
        i_reset = 1'b1;
        i_m0_address = '0; i_m0_read = 0; i_m0_write = 0; i_m0_writedata = '0; i_m0_byteenable = '0;
        i_m1_address = '0; i_m1_read = 0; i_m1_write = 0; i_m1_writedata = '0; i_m1_byteenable = '0;
        i_s_waitrequest = 1'b0; i_s_readdata = '0;
        d4[0] = 32'hA0A0_0001; d4[1] = 32'hB1B1_0002; d4[2] = 32'hC2C2_0003;
`ifdef ARB_ROUND_ROBIN_EN
        g4[0] = 2'b01; g4[1] = 2'b10; g4[2] = 2'b01;
`else
        g4[0] = 2'b10; g4[1] = 2'b10; g4[2] = 2'b10;
`endif
        cyc(); cyc();
        i_reset = 1'b0;
        sample();
        chk_idle("reset");
        chk("reset_wr0", {31'd0, o_m0_waitrequest}, 32'd1);
        chk("reset_wr1", {31'd0, o_m1_waitrequest}, 32'd1);

        // m0 instruction-fetch read, zero-wait memory
        cyc();
        i_m0_read = 1; i_m0_address = 32'hBFC0_0000; i_s_readdata = 32'h3C08_BFC0;
        push(0, 1, 32'h3C08_BFC0);
        sample(); chk_idle("t1_idle");
        cyc(); sample();
        chk("t1_sread", {31'd0, o_s_read}, 32'd1);
        chk("t1_saddr", o_s_address, 32'hBFC0_0000);
        chk("t1_grant", {30'd0, o_grant}, 32'd1);
        chk("t1_issue_wr0", {31'd0, o_m0_waitrequest}, 32'd1);
        cyc(); sample();
        chk("t1_rdata_sread", {31'd0, o_s_read}, 32'd0);
        chk("t1_rdata_grant", {30'd0, o_grant}, 32'd1);
        cyc();
        i_m0_read = 0;
        sample(); chk_idle("t1_end");

        // m1 write stalled three cycles by the memory
        cyc();
        i_m1_write = 1; i_m1_address = 32'hBFC0_0030; i_m1_writedata = 32'h0000_0001;
        i_m1_byteenable = 4'hF; i_s_waitrequest = 1;
        push(1, 0, 32'd0);
        sample(); chk_idle("t2_idle");
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 3) i_s_waitrequest = 0;
            sample();
            chk("t2_swrite", {31'd0, o_s_write}, 32'd1);
            chk("t2_saddr", o_s_address, 32'hBFC0_0030);
            chk("t2_wdata", o_s_writedata, 32'h0000_0001);
            chk("t2_be", {28'd0, o_s_byteenable}, 32'hF);
            chk("t2_grant", {30'd0, o_grant}, 32'd2);
            chk("t2_wr0", {31'd0, o_m0_waitrequest}, 32'd1);
            if (k < 3) chk("t2_stall_wr1", {31'd0, o_m1_waitrequest}, 32'd1);
        end
        cyc();
        i_m1_write = 0;
        sample(); chk_idle("t2_end");

        // m0 read+write together behaves as a write
        cyc();
        i_m0_read = 1; i_m0_write = 1; i_m0_address = 32'h0000_0010;
        i_m0_writedata = 32'hDEAD_BEEF; i_m0_byteenable = 4'b0011;
        push(0, 0, 32'd0);
        sample(); chk_idle("t3_idle");
        cyc(); sample();
        chk("t3_swrite", {31'd0, o_s_write}, 32'd1);
        chk("t3_sread", {31'd0, o_s_read}, 32'd0);
        chk("t3_be", {28'd0, o_s_byteenable}, 32'h3);
        chk("t3_wdata", o_s_writedata, 32'hDEAD_BEEF);
        cyc();
        i_m0_read = 0; i_m0_write = 0;
        sample(); chk_idle("t3_end");

        // both masters read continuously from a fresh reset: tie-break order
        cyc();
        i_reset = 1;
        cyc();
        i_reset = 0;
        i_m0_read = 1; i_m0_address = 32'h0000_0200;
        i_m1_read = 1; i_m1_address = 32'h0000_0100;
        for (int k = 0; k < 3; k++) begin
            i_s_readdata = d4[k];
            push(g4[k][1], 1, d4[k]);
            sample();
            chk("t4_idle_grant", {30'd0, o_grant}, 32'd0);
            cyc(); sample();
            chk("t4_issue_grant", {30'd0, o_grant}, {30'd0, g4[k]});
            chk("t4_saddr", o_s_address, g4[k][1] ? 32'h0000_0100 : 32'h0000_0200);
            cyc(); sample();
            chk("t4_rdata_grant", {30'd0, o_grant}, {30'd0, g4[k]});
            cyc();
        end
        i_m0_read = 0; i_m1_read = 0;
        sample(); chk_idle("t4_end");

        // reset lands while m1 read is in ISSUE; transfer must vanish
        cyc();
        i_m1_read = 1; i_m1_address = 32'h0000_0300; i_s_waitrequest = 0;
        sample(); chk_idle("t5_idle");
        cyc(); sample();
        chk("t5_issue_grant", {30'd0, o_grant}, 32'd2);
        chk("t5_issue_sread", {31'd0, o_s_read}, 32'd1);
        i_reset = 1;
        cyc();
        i_reset = 0; i_m1_read = 0;
        sample();
        chk_idle("t5_after_reset");
        chk("t5_wr1", {31'd0, o_m1_waitrequest}, 32'd1);
        cyc();
        i_m0_write = 1; i_m0_address = 32'h0000_0040; i_m0_writedata = 32'h1234_5678;
        i_m0_byteenable = 4'hF;
        push(0, 0, 32'd0);
        sample(); chk_idle("t5b_idle");
        cyc(); sample();
        chk("t5b_swrite", {31'd0, o_s_write}, 32'd1);
        chk("t5b_grant", {30'd0, o_grant}, 32'd1);
        cyc();
        i_m0_write = 0;
        sample(); chk_idle("t5b_end");

        // owner drops its strobe while stalled: abort without completion
        cyc();
        i_m1_write = 1; i_m1_address = 32'h0000_0050; i_s_waitrequest = 1;
        sample();
        cyc(); sample();
        chk("t6_grant", {30'd0, o_grant}, 32'd2);
        chk("t6_swrite", {31'd0, o_s_write}, 32'd1);
        i_m1_write = 0;
        cyc(); sample();
        chk_idle("t6_abort");
        chk("t6_wr1", {31'd0, o_m1_waitrequest}, 32'd1);
        i_s_waitrequest = 0;

        cyc(); cyc(); sample();
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
